snn_img_loader: RTL and testbench
=================================

SNN_IMG_LOADER -- requirements
Module: snn_img_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 rx_rdy  input  1  one-cycle strobe: rx_data holds a new received byte.
REQ-005 rx_data  input  8  received byte.
REQ-006 addr_input_unit  input  10  pixel read address driven by snn_core, range 0..783.
REQ-007 q_input  output  1  pixel value at addr_input_unit.
REQ-008 start  output  1  one-cycle pulse to snn_core: the image is complete.
REQ-009 done  input  1  level from snn_core: classification finished.
REQ-010 digit  input  4  classified digit from snn_core, valid while done=1.
REQ-011 tx_start  output  1  one-cycle pulse: send tx_data.
REQ-012 tx_data  output  8  result byte, ASCII 8'h30 + digit.
REQ-013 tx_rdy  input  1  level: the transmitter is idle and can accept tx_start.
REQ-014 busy  output  1  high in every state except LOAD.

Function
REQ-015 The state machine SHALL have the states LOAD, START, WAIT, SEND and HOLD.
REQ-016 In LOAD, each rx_rdy strobe SHALL write pixels into the image buffer at a pixel counter, then advance the counter.
REQ-017 When the last pixel (index 783) is written, the block SHALL go to START, and the pixel counter SHALL return to 0.
REQ-018 START SHALL assert start for exactly one cycle, then the block SHALL go to WAIT.
REQ-019 In WAIT, when done=1, the block SHALL latch digit and go to SEND; done is ignored in every other state.
REQ-020 In SEND, when tx_rdy=1, the block SHALL pulse tx_start for one cycle with tx_data = 8'h30 + latched digit, and go to HOLD.
REQ-021 In HOLD, the block SHALL wait for done=0, then go to LOAD.
REQ-022 q_input SHALL be registered: it reflects the buffer at the addr_input_unit of the previous cycle (1-cycle read latency, the same timing as the RAMs).
REQ-023 An addr_input_unit value above 783 SHALL read as 0.
REQ-024 rx_rdy strobes received in any state other than LOAD SHALL be dropped without changing the buffer or the counter.
REQ-025 Reads SHALL stay permitted in every state; a read of an address in the same cycle it is written SHALL return the old value.
REQ-026 The image buffer SHALL NOT be cleared between images; every pixel is overwritten on each load.

Reset
REQ-027 On rst: state = LOAD, pixel counter = 0, start = 0, tx_start = 0, tx_data = 8'h00, q_input = 0, busy = 0, latched digit = 0.
REQ-028 On rst: the image buffer contents are unspecified and SHALL NOT be cleared.
REQ-029 rst SHALL take priority over every other input in the same cycle.
REQ-030 A reset in any state SHALL abort the operation; the next image is loaded from pixel 0.

Configuration
REQ-031 With SNN_LOADER_ASCII_EN defined, each byte SHALL carry one pixel: 8'h31 stores 1, 8'h30 stores 0, and 784 bytes form an image.
REQ-032 With SNN_LOADER_ASCII_EN defined, any other byte value SHALL be discarded and SHALL NOT advance the counter.
REQ-033 Without SNN_LOADER_ASCII_EN, each byte SHALL carry 8 pixels, LSB = lowest index; the counter advances by 8, and 98 bytes form an image.
REQ-034 Without SNN_LOADER_ASCII_EN, every byte value SHALL be accepted.

Structure
REQ-035 Package snn_pkg SHALL hold the state enum loader_state_t, IMG_PIXELS = 784, IMG_BYTES = 98 and ASCII_ZERO = 8'h30.
REQ-036 The buffer SHALL be one sub-module, snn_img_ram: 784x1, synchronous write, registered read, 8-bit-wide write port with a per-bit enable.
REQ-037 The state machine, counter and byte unpacking SHALL be in snn_img_loader.

Verification
REQ-038 ASCII mode: 784 bytes alternating '1'/'0' -> one start pulse after the last byte; q_input at address 0 = 1, at 1 = 0, at 783 = 0, one cycle after the address.
REQ-039 Packed mode: 98 bytes of 8'hA5 -> start pulse; pixels 0..7 read 1,0,1,0,0,1,0,1.
REQ-040 Hold done=1 with digit=7 and tx_rdy=0 for 5 cycles, then raise tx_rdy -> a single tx_start with tx_data = 8'h37; return to LOAD only after done falls.
REQ-041 ASCII mode: insert 8'h41 and 8'h0A between pixel bytes -> the counter is not advanced and start still occurs after exactly 784 valid bytes.
REQ-042 Send 20 bytes while busy=1, then 784 bytes in LOAD -> the buffer holds only the second image and there is one start per image.
REQ-043 Assert rst after 400 pixels -> busy = 0 and no start; the next 784 bytes produce a start.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN image loader.
package snn_pkg;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        HOLD  = 3'd4
    } loader_state_t;

    localparam int IMG_PIXELS = 784;
    localparam int IMG_BYTES  = 98;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;

endpackage

// File: rtl/snn_img_ram.sv
// 784x1 image buffer: byte-wide write port with per-bit enable, registered 1-bit read.
module snn_img_ram
    import snn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] wbe,
    input  logic [9:0] raddr,
    output logic       q
);

    logic [7:0] mem [IMG_BYTES];

    // Contents are deliberately not reset; every load overwrites all pixels.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wbe[i]) mem[waddr][i] <= wdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else if (raddr < 10'(IMG_PIXELS))
            q <= mem[raddr[9:3]][raddr[2:0]];
        else
            q <= 1'b0;
    end

endmodule

// File: rtl/snn_img_loader.sv
// Receives an image over a byte stream, kicks snn_core, and returns the digit as ASCII.
// Build option SNN_LOADER_ASCII_EN: one ASCII '0'/'1' pixel per byte instead of 8 packed pixels.
module snn_img_loader
    import snn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic [9:0] addr_input_unit,
    output logic       q_input,
    output logic       start,
    input  logic       done,
    input  logic [3:0] digit,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_rdy,
    output logic       busy
);

    loader_state_t state;
    logic [9:0]    pix_cnt;
    logic [3:0]    digit_q;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic [7:0]    wr_be;
    logic          last_px;

`ifdef SNN_LOADER_ASCII_EN
    localparam logic [9:0] PX_STEP = 10'd1;
    logic px_valid;
    assign px_valid = (rx_data == ASCII_ONE) || (rx_data == ASCII_ZERO);
    assign wr_en    = (state == LOAD) && rx_rdy && px_valid;
    assign wr_data  = {8{rx_data == ASCII_ONE}};
    assign wr_be    = 8'd1 << pix_cnt[2:0];
    assign last_px  = (pix_cnt == 10'(IMG_PIXELS - 1));
`else
    localparam logic [9:0] PX_STEP = 10'd8;
    assign wr_en    = (state == LOAD) && rx_rdy;
    assign wr_data  = rx_data;
    assign wr_be    = 8'hFF;
    assign last_px  = (pix_cnt == 10'(IMG_PIXELS - 8));
`endif

    snn_img_ram u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (pix_cnt[9:3]),
        .wdata (wr_data),
        .wbe   (wr_be),
        .raddr (addr_input_unit),
        .q     (q_input)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            pix_cnt  <= 10'd0;
            digit_q  <= 4'd0;
            start    <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
        end else begin
            start    <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                LOAD: begin
                    if (wr_en) begin
                        if (last_px) begin
                            pix_cnt <= 10'd0;
                            state   <= START;
                            start   <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + PX_STEP;
                        end
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (done) begin
                        digit_q <= digit;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (tx_rdy) begin
                        tx_start <= 1'b1;
                        tx_data  <= ASCII_ZERO + {4'd0, digit_q};
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // done is a level; wait for core to drop it so one result is sent once
                    if (!done) begin
                        state <= LOAD;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_img_loader.sv
// Directed self-checking bench for snn_img_loader (packed or ASCII build).
module tb_snn_img_loader;
    import snn_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] addr_input_unit = 10'd0;
    logic       q_input;
    logic       start;
    logic       done = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_rdy = 1'b0;
    logic       busy;

    int passes = 0;
    int total  = 0;
    int start_cnt = 0;
    int tx_cnt = 0;
    int snap;
    logic px;

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (start)    start_cnt <= start_cnt + 1;
        if (tx_start) tx_cnt    <= tx_cnt + 1;
    end

    snn_img_loader dut (
        .clk             (clk),
        .rst             (rst),
        .rx_rdy          (rx_rdy),
        .rx_data         (rx_data),
        .addr_input_unit (addr_input_unit),
        .q_input         (q_input),
        .start           (start),
        .done            (done),
        .digit           (digit),
        .tx_start        (tx_start),
        .tx_data         (tx_data),
        .tx_rdy          (tx_rdy),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_rdy  = 1'b1;
        @(posedge clk);
        #1;
        rx_rdy  = 1'b0;
    endtask

    // One group = 8 pixels, LSB first: a single packed byte or eight ASCII bytes.
    task automatic send_group(input logic [7:0] b);
`ifdef SNN_LOADER_ASCII_EN
        for (int i = 0; i < 8; i++) send_byte(ASCII_ZERO + {7'd0, b[i]});
`else
        send_byte(b);
`endif
    endtask

    task automatic read_px(input logic [9:0] a, output logic v);
        @(posedge clk);
        #1;
        addr_input_unit = a;
        @(posedge clk);
        #1;
        v = q_input;
    endtask

    initial begin
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_q", q_input, 0);
        rst = 1'b0;
        tick(1);

        // First image: all groups 8'hA5
        for (int g = 0; g < IMG_BYTES - 1; g++) begin
            send_group(8'hA5);
`ifdef SNN_LOADER_ASCII_EN
            if (g == 10) begin
                send_byte(8'h41);
                send_byte(8'h0A);
            end
`endif
        end
        check("no_early_start", start_cnt, 0);
        check("busy_in_load", busy, 0);
        send_group(8'hA5);
        check("start_pulse", start, 1);
        check("busy_after_load", busy, 1);
        tick(3);
        check("start_once", start_cnt, 1);
        check("start_low", start, 0);

        read_px(10'd0, px); check("a5_px0", px, 1);
        read_px(10'd1, px); check("a5_px1", px, 0);
        read_px(10'd2, px); check("a5_px2", px, 1);
        read_px(10'd3, px); check("a5_px3", px, 0);
        read_px(10'd5, px); check("a5_px5", px, 1);
        read_px(10'd6, px); check("a5_px6", px, 0);
        read_px(10'd783, px); check("a5_px783", px, 1);
        read_px(10'd800, px); check("oob_read", px, 0);

        // Bytes while busy must be dropped
        for (int i = 0; i < 20; i++) send_byte(8'h00);
        read_px(10'd0, px); check("drop_px0", px, 1);
        check("drop_no_start", start_cnt, 1);

        // Result handshake
        done  = 1'b1;
        digit = 4'd7;
        tick(5);
        check("no_tx_without_rdy", tx_cnt, 0);
        tx_rdy = 1'b1;
        tick(1);
        check("tx_start_pulse", tx_start, 1);
        check("tx_data", tx_data, 8'h37);
        digit = 4'd2;
        tick(3);
        check("tx_once", tx_cnt, 1);
        check("hold_busy", busy, 1);
        done = 1'b0;
        tick(1);
        check("back_to_load", busy, 0);
        tx_rdy = 1'b0;

        // Second image: 8'h3C, buffer must reflect only this image
        for (int g = 0; g < IMG_BYTES; g++) send_group(8'h3C);
        tick(2);
        check("start_img2", start_cnt, 2);
        read_px(10'd0, px); check("3c_px0", px, 0);
        read_px(10'd2, px); check("3c_px2", px, 1);
        read_px(10'd5, px); check("3c_px5", px, 1);
        read_px(10'd6, px); check("3c_px6", px, 0);

        // Finish that transaction, then abort a load by reset
        done = 1'b1; digit = 4'd0; tx_rdy = 1'b1;
        tick(3);
        check("tx_data_zero", tx_data, 8'h30);
        done = 1'b0; tx_rdy = 1'b0;
        tick(2);
        check("load_again", busy, 0);
        for (int g = 0; g < 50; g++) send_group(8'hFF);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_no_start", start_cnt, 2);
        snap = start_cnt;
        for (int g = 0; g < IMG_BYTES - 1; g++) send_group(8'h0F);
        check("post_rst_no_early", start_cnt, snap);
        send_group(8'h0F);
        tick(2);
        check("post_rst_start", start_cnt, snap + 1);
        read_px(10'd3, px); check("0f_px3", px, 1);
        read_px(10'd4, px); check("0f_px4", px, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
